blake2s_block_sched: RTL

Block scheduler that sequences the BLAKE2s hash core. It takes a byte stream from the I/O interface, frames it into 64-byte blocks with a zero-padded key block when a key is present, and drives the core's byte-write port with per-block first/last flags. It stalls between blocks until the core reports that compression is done. It sits between `io_intf` and `blake2s_hash256`.

---
 rtl/blake2s_block_sched.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/blake2s_block_sched.sv
// blake2s_block_sched
// Frames a key + message byte stream into 64-byte BLAKE2s blocks for the hash
// core. The key (if any) gets its own zero-padded block. The message tail is
// zero padded to 64 bytes. Each byte is tagged with first/last-block flags.
// Between blocks the scheduler waits for the core's blk_done_i.
//
// Build option: define BLAKE2S_SCHED_ABORT_EN to add the synchronous abort_i
// input. Without it, only nreset can end a hash that is in progress.
module blake2s_block_sched (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start_i,
  input  logic [7:0]  kk_i,
  input  logic [63:0] ll_i,
  input  logic        src_valid_i,
  input  logic [7:0]  src_data_i,
  output logic        src_ready_o,
  input  logic        blk_done_i,
  output logic        data_v_o,
  output logic [7:0]  data_o,
  output logic [5:0]  data_idx_o,
  output logic        block_first_o,
  output logic        block_last_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
`ifdef BLAKE2S_SCHED_ABORT_EN
  ,
  input  logic        abort_i
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_KEY  = 3'd1;
  localparam logic [2:0] S_KPAD = 3'd2;
  localparam logic [2:0] S_MSG  = 3'd3;
  localparam logic [2:0] S_MPAD = 3'd4;
  localparam logic [2:0] S_WAIT = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]  state, state_n;
  logic [5:0]  idx, idx_n;
  logic [5:0]  kk, kk_n;
  logic [63:0] rem, rem_n;
  logic        first, first_n;
  logic        last_blk, last_n;

  logic        ready_n, busy_n, done_n, err_n;
  logic        dv_n, first_out_n, last_out_n;
  logic [7:0]  dat_n;
  logic [5:0]  idx_out_n;
  logic        accept;
  logic        abort;

`ifdef BLAKE2S_SCHED_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  // src_ready_o is a registered function of state, so it is valid as an accept qualifier
  assign accept = src_valid_i && src_ready_o;

  // Next-state, block bookkeeping and next output values
  always_comb begin
    state_n = state;
    idx_n   = idx;
    kk_n    = kk;
    rem_n   = rem;
    first_n = first;
    last_n  = last_blk;
    dv_n    = 1'b0;
    dat_n   = '0;
    done_n  = 1'b0;
    err_n   = 1'b0;

    case (state)
      S_IDLE: begin
        if (start_i) begin
          if (kk_i > 8'd32) begin
            err_n = 1'b1;
          end else begin
            kk_n    = kk_i[5:0];
            rem_n   = ll_i;
            first_n = 1'b1;
            idx_n   = '0;
            // A key block is last only when no message follows; otherwise the
            // first message block is last when the whole message fits in it.
            if (kk_i != 8'd0) begin
              last_n  = (ll_i == 64'd0);
              state_n = S_KEY;
            end else if (ll_i != 64'd0) begin
              last_n  = (ll_i <= 64'd64);
              state_n = S_MSG;
            end else begin
              last_n  = 1'b1;
              state_n = S_MPAD;
            end
          end
        end
      end

      S_KEY: begin
        if (accept) begin
          dv_n  = 1'b1;
          dat_n = src_data_i;
          idx_n = idx + 6'd1;
          if (idx == kk - 6'd1) begin
            state_n = S_KPAD;
          end
        end
      end

      S_KPAD: begin
        dv_n  = 1'b1;
        idx_n = idx + 6'd1;
        if (idx == 6'd63) begin
          state_n = S_WAIT;
        end
      end

      S_MSG: begin
        if (accept) begin
          dv_n  = 1'b1;
          dat_n = src_data_i;
          idx_n = idx + 6'd1;
          rem_n = rem - 64'd1;
          // A full block takes precedence: the final byte landing on idx 63
          // needs no padding.
          if (idx == 6'd63) begin
            state_n = S_WAIT;
          end else if (rem == 64'd1) begin
            state_n = S_MPAD;
          end
        end
      end

      S_MPAD: begin
        dv_n  = 1'b1;
        idx_n = idx + 6'd1;
        if (idx == 6'd63) begin
          state_n = S_WAIT;
        end
      end

      S_WAIT: begin
        if (blk_done_i) begin
          first_n = 1'b0;
          if (last_blk || (rem == 64'd0)) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            last_n  = (rem <= 64'd64);
            state_n = S_MSG;
          end
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (abort) begin
      state_n = S_IDLE;
      dv_n    = 1'b0;
      done_n  = 1'b0;
      err_n   = 1'b0;
    end

    // Write-side sideband is only meaningful alongside a byte write
    idx_out_n   = dv_n ? idx : '0;
    first_out_n = dv_n & first;
    last_out_n  = dv_n & last_blk;
    if (!dv_n) begin
      dat_n = '0;
    end

    ready_n = (state_n == S_KEY) || (state_n == S_MSG);
    busy_n  = (state_n != S_IDLE);
  end

  // Scheduler state registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= S_IDLE;
      idx      <= '0;
      kk       <= '0;
      rem      <= '0;
      first    <= 1'b0;
      last_blk <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      kk       <= kk_n;
      rem      <= rem_n;
      first    <= first_n;
      last_blk <= last_n;
    end
  end

  // Registered outputs: one cycle from accept/pad decision to core write
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      src_ready_o   <= 1'b0;
      data_v_o      <= 1'b0;
      data_o        <= '0;
      data_idx_o    <= '0;
      block_first_o <= 1'b0;
      block_last_o  <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      src_ready_o   <= ready_n;
      data_v_o      <= dv_n;
      data_o        <= dat_n;
      data_idx_o    <= idx_out_n;
      block_first_o <= first_out_n;
      block_last_o  <= last_out_n;
      busy_o        <= busy_n;
      done_o        <= done_n;
      err_o         <= err_n;
    end
  end

endmodule
